// File: rtl/dma_pkg.sv
// Shared definitions for the disk-to-memory DMA sequencer:
//   - register offsets (decoded on addr[3:2])
//   - FSM state encoding
//   - beat length / byte-strobe helpers and the strobed register-merge helper
package dma_pkg;

  localparam logic [3:0] DMA_REG_DISK_ADDR = 4'h0;
  localparam logic [3:0] DMA_REG_MEM_ADDR  = 4'h4;
  localparam logic [3:0] DMA_REG_T_SIZE    = 4'h8;
  localparam logic [3:0] DMA_REG_INIT_TRAN = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DSK_RD,
    ST_MEM_WR,
    ST_DONE
  } dma_state_e;

  // Bytes moved in one beat: fill up to the next word boundary, but never
  // past the end of the transfer.
  function automatic logic [2:0] beat_len(input logic [1:0] off, input logic [31:0] remain);
    logic [2:0] room;
    room = 3'd4 - {1'b0, off};
    if (remain < {29'd0, room}) return remain[2:0];
    return room;
  endfunction

  // n contiguous byte lanes starting at lane 'off'.
  function automatic logic [3:0] beat_strb(input logic [1:0] off, input logic [2:0] n);
    logic [3:0] ones;
    ones = 4'((5'd1 << n) - 5'd1);
    return ones << off;
  endfunction

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/dma_reg_if.sv
// Register slave for the DMA sequencer.
//   s_*        : bus slave request/response; s_ack is a one-cycle registered pulse
//                issued the cycle after s_cyc is sampled with s_ack low.
//   busy/interrupt : status from the sequencer, read back at INIT_TRAN.
//   start      : one-cycle pulse after an accepted INIT_TRAN write with bit0 set.
//   disk_addr/mem_addr/t_size : programmed values for the sequencer.
// Writes are byte-strobed and dropped (but still acked) while busy.
module dma_reg_if import dma_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int SIZE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_cyc,
  input  logic              s_we,
  input  logic [3:0]        s_strb,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [31:0]       s_data_i,
  output logic              s_ack,
  output logic [31:0]       s_data_o,
  input  logic              busy,
  input  logic              interrupt,
  output logic              start,
  output logic [ADDR_W-1:0] disk_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [SIZE_W-1:0] t_size
);

  logic        sample, wr_ok;
  logic [3:0]  reg_off;
  logic [31:0] rd_mux;
  logic        unused_addr;

  assign sample      = s_cyc && !s_ack;
  assign wr_ok       = sample && s_we && !busy;
  assign reg_off     = {s_addr[3:2], 2'b00};
  assign unused_addr = ^{s_addr[ADDR_W-1:4], s_addr[1:0]};

  always_comb begin
    rd_mux = '0;
    case (reg_off)
      DMA_REG_DISK_ADDR: rd_mux = 32'(disk_addr);
      DMA_REG_MEM_ADDR:  rd_mux = 32'(mem_addr);
      DMA_REG_T_SIZE:    rd_mux = 32'(t_size);
      default:           rd_mux = {30'd0, interrupt, busy};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack     <= 1'b0;
      s_data_o  <= '0;
      start     <= 1'b0;
      disk_addr <= '0;
      mem_addr  <= '0;
      t_size    <= '0;
    end else begin
      s_ack <= sample;
      start <= wr_ok && (reg_off == DMA_REG_INIT_TRAN) && s_strb[0] && s_data_i[0];
      if (sample) s_data_o <= rd_mux;
      if (wr_ok) begin
        case (reg_off)
          DMA_REG_DISK_ADDR: disk_addr <= ADDR_W'(merge_strb(32'(disk_addr), s_data_i, s_strb));
          DMA_REG_MEM_ADDR:  mem_addr  <= ADDR_W'(merge_strb(32'(mem_addr), s_data_i, s_strb));
          DMA_REG_T_SIZE:    t_size    <= SIZE_W'(merge_strb(32'(t_size), s_data_i, s_strb));
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/dma_xfer_ctrl.sv
// Disk-to-memory DMA sequencer.
//   s_*   : register slave (DISK_ADDR, MEM_ADDR, T_SIZE, INIT_TRAN)
//   m_*   : memory write master, byte-strobed, held until m_ack
//   dsk_* : disk byte-read request (1..4 bytes, right-justified data)
//   interrupt : level completion flag, cleared by int_clear (set wins)
//   busy  : transfer in progress
// Each beat moves up to the next word boundary, so only the first beat can
// be unaligned; the last one may be short.
module dma_xfer_ctrl import dma_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int SIZE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_cyc,
  input  logic              s_we,
  input  logic [3:0]        s_strb,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [31:0]       s_data_i,
  output logic              s_ack,
  output logic [31:0]       s_data_o,
  output logic              m_cyc,
  output logic              m_we,
  output logic [3:0]        m_strb,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_data_o,
  input  logic              m_ack,
  input  logic [31:0]       m_data_i,
  output logic              dsk_rd_req,
  output logic [ADDR_W-1:0] dsk_addr,
  output logic [2:0]        dsk_len,
  input  logic              dsk_rd_vld,
  input  logic [31:0]       dsk_rd_data,
  output logic              interrupt,
  input  logic              int_clear,
  output logic              busy
);

  logic              start;
  logic [ADDR_W-1:0] disk_addr, mem_addr;
  logic [SIZE_W-1:0] t_size;

  dma_state_e        state;
  logic [ADDR_W-1:0] cur_dsk, cur_mem;
  logic [SIZE_W-1:0] remain, remain_nxt;
  logic [1:0]        off;
  logic [2:0]        n;
  logic              unused_rdata;

  dma_reg_if #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_cyc     (s_cyc),
    .s_we      (s_we),
    .s_strb    (s_strb),
    .s_addr    (s_addr),
    .s_data_i  (s_data_i),
    .s_ack     (s_ack),
    .s_data_o  (s_data_o),
    .busy      (busy),
    .interrupt (interrupt),
    .start     (start),
    .disk_addr (disk_addr),
    .mem_addr  (mem_addr),
    .t_size    (t_size)
  );

  // Beat geometry comes straight from the working registers, which only
  // move on m_ack, so it is stable across DSK_RD and MEM_WR of one beat.
  assign off          = cur_mem[1:0];
  assign n            = beat_len(off, 32'(remain));
  assign remain_nxt   = remain - SIZE_W'(n);
  assign dsk_addr     = cur_dsk;
  assign dsk_len      = n;
  assign m_addr       = {cur_mem[ADDR_W-1:2], 2'b00};
  assign unused_rdata = ^m_data_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur_dsk    <= '0;
      cur_mem    <= '0;
      remain     <= '0;
      busy       <= 1'b0;
      interrupt  <= 1'b0;
      dsk_rd_req <= 1'b0;
      m_cyc      <= 1'b0;
      m_we       <= 1'b0;
      m_strb     <= '0;
      m_data_o   <= '0;
    end else begin
      // Placed before the FSM so a completion in the same cycle overrides it.
      if (int_clear) interrupt <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          cur_dsk <= disk_addr;
          cur_mem <= mem_addr;
          remain  <= t_size;
          busy    <= 1'b1;
          if (t_size == '0) state <= ST_DONE;
          else begin
            state      <= ST_DSK_RD;
            dsk_rd_req <= 1'b1;
          end
        end
        ST_DSK_RD: if (dsk_rd_vld) begin
          dsk_rd_req <= 1'b0;
          m_data_o   <= dsk_rd_data << {off, 3'b000};
          m_strb     <= beat_strb(off, n);
          m_cyc      <= 1'b1;
          m_we       <= 1'b1;
          state      <= ST_MEM_WR;
        end
        ST_MEM_WR: if (m_ack) begin
          m_cyc   <= 1'b0;
          m_we    <= 1'b0;
          cur_mem <= cur_mem + ADDR_W'(n);
          cur_dsk <= cur_dsk + ADDR_W'(n);
          remain  <= remain_nxt;
          if (remain_nxt != '0) begin
            state      <= ST_DSK_RD;
            dsk_rd_req <= 1'b1;
          end else state <= ST_DONE;
        end
        default: begin
          interrupt <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
